lif_layer: RTL and testbench

- Parametrised, fully connected layer of integrate-and-fire output neurons; next generation of if_network.
- Adds a runtime-writable signed weight matrix, a timestep valid strobe, saturating signed membrane arithmetic with a floor, and an optional leak.
- Sits between spike sources (encoders or a previous layer) and spike consumers or counters. One timestep is processed per cycle in which spike_valid is high.

---
 rtl/lif_layer.sv | 139 +++++++++++++
 tb/tb_lif_layer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_layer.sv
// -----------------------------------------------------------------------------
// lif_layer
//   Fully connected layer of integrate-and-fire output neurons with a
//   runtime-writable signed weight matrix, saturating signed membrane
//   arithmetic floored at RESET, a refractory window and an optional leak.
//   One timestep is evaluated on every clk edge where spike_valid is high.
//
// Optional feature:
//   LIF_LEAK_EN  when defined, LEAK is subtracted on every non-refractory
//                valid timestep; when undefined the layer is a pure IF layer
//                and LEAK is ignored.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   spike_valid  timestep strobe; spike_in is sampled when high
//   spike_in     input spike lines for this timestep
//   wr_en        weight write enable
//   wr_addr      weight index = out*NUM_INPUTS + in (out-of-range ignored)
//   wr_data      signed weight value
//   spike_out    registered one-cycle spike pulses, one per output neuron
//   refrac_busy  registered, high while a neuron's refractory count != 0
// -----------------------------------------------------------------------------
module lif_layer #(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_OUTPUTS = 2,
   parameter int WEIGHT_SIZE = 8,
   parameter int POT_SIZE    = 16,
   parameter int THRESH      = 15,
   parameter int RESET       = 0,
   parameter int REFRAC      = 5,
   parameter int LEAK        = 1
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic                                                 spike_valid,
   input  logic [NUM_INPUTS-1:0]                                spike_in,
   input  logic                                                 wr_en,
   input  logic [$clog2(NUM_INPUTS*NUM_OUTPUTS)-1:0]            wr_addr,
   input  logic [WEIGHT_SIZE-1:0]                               wr_data,
   output logic [NUM_OUTPUTS-1:0]                               spike_out,
   output logic [NUM_OUTPUTS-1:0]                               refrac_busy
);

   localparam int NUM_W = NUM_INPUTS * NUM_OUTPUTS;
   localparam int RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam int SW    = POT_SIZE + 2;

   // Arithmetic is done two bits wider than the potential so that the
   // accumulated weights plus the current potential can never wrap before
   // saturation is applied.
   localparam logic signed [SW-1:0] SAT_MAX  = {3'b000, {(POT_SIZE-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN  = {3'b111, {(POT_SIZE-1){1'b0}}};
   localparam logic signed [SW-1:0] RESET_X  = SW'(RESET);
   localparam logic signed [SW-1:0] THRESH_X = SW'(THRESH);
`ifdef LIF_LEAK_EN
   localparam logic signed [SW-1:0] LEAK_X   = SW'(LEAK);
`endif

   logic signed [WEIGHT_SIZE-1:0] r_weight [NUM_W];
   logic signed [POT_SIZE-1:0]    r_pot    [NUM_OUTPUTS];
   logic        [RW-1:0]          r_refrac [NUM_OUTPUTS];
   logic        [NUM_OUTPUTS-1:0] r_spike;
   logic        [NUM_OUTPUTS-1:0] r_busy;

   logic signed [SW-1:0]          w_sum    [NUM_OUTPUTS];
   logic signed [SW-1:0]          w_clip   [NUM_OUTPUTS];
   logic signed [POT_SIZE-1:0]    w_result [NUM_OUTPUTS];
   logic        [NUM_OUTPUTS-1:0] w_fire;

   // Integration for every neuron, based on the currently stored weights
   // (a write on the same edge takes effect from the next timestep).
   always_comb begin
      w_fire = '0;
      for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
         w_sum[j] = SW'(r_pot[j]);
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (spike_in[i]) begin
               w_sum[j] = w_sum[j] + SW'(r_weight[j*NUM_INPUTS + i]);
            end
         end
`ifdef LIF_LEAK_EN
         w_sum[j] = w_sum[j] - LEAK_X;
`endif
         if (w_sum[j] > SAT_MAX) begin
            w_clip[j] = SAT_MAX;
         end else if (w_sum[j] < SAT_MIN) begin
            w_clip[j] = SAT_MIN;
         end else begin
            w_clip[j] = w_sum[j];
         end
         if (w_clip[j] < RESET_X) begin
            w_clip[j] = RESET_X;
         end
         w_result[j] = w_clip[j][POT_SIZE-1:0];
         w_fire[j]   = (w_clip[j] >= THRESH_X);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_weight <= '{default: '0};
         r_pot    <= '{default: '0};
         r_refrac <= '{default: '0};
         r_spike  <= '0;
         r_busy   <= '0;
      end else begin
         if (wr_en && (int'(wr_addr) < NUM_W)) begin
            r_weight[wr_addr] <= wr_data;
         end
         for (int unsigned j = 0; j < NUM_OUTPUTS; j++) begin
            if (spike_valid) begin
               if (r_refrac[j] != '0) begin
                  // Refractory: count down, hold at RESET, ignore input.
                  r_refrac[j] <= r_refrac[j] - RW'(1);
                  r_pot[j]    <= POT_SIZE'(RESET);
                  r_spike[j]  <= 1'b0;
                  r_busy[j]   <= (r_refrac[j] != RW'(1));
               end else if (w_fire[j]) begin
                  r_refrac[j] <= RW'(REFRAC);
                  r_pot[j]    <= POT_SIZE'(RESET);
                  r_spike[j]  <= 1'b1;
                  r_busy[j]   <= (REFRAC != 0);
               end else begin
                  r_pot[j]    <= w_result[j];
                  r_spike[j]  <= 1'b0;
                  r_busy[j]   <= 1'b0;
               end
            end else begin
               r_spike[j] <= 1'b0;
            end
         end
      end
   end

   assign spike_out   = r_spike;
   assign refrac_busy = r_busy;

endmodule

// File: tb/tb_lif_layer.sv
// -----------------------------------------------------------------------------
// tb_lif_layer
//   Self-checking bench for lif_layer: directed scenarios followed by random
//   timesteps and weight writes, all compared against an integer model of
//   the neuron rules.
// -----------------------------------------------------------------------------
module tb_lif_layer;

   localparam int NI = 4;
   localparam int NO = 2;
   localparam int WS = 8;
   localparam int PS = 16;
   localparam int TH = 15;
   localparam int RS = 0;
   localparam int RF = 5;
   localparam int LK = 1;
   localparam int NW = NI * NO;
   localparam int PMAX = 32767;
   localparam int PMIN = -32768;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          spike_valid = 1'b0;
   logic [NI-1:0] spike_in = '0;
   logic          wr_en = 1'b0;
   logic [2:0]    wr_addr = '0;
   logic [WS-1:0] wr_data = '0;
   logic [NO-1:0] spike_out;
   logic [NO-1:0] refrac_busy;

   always #5 clk = ~clk;

   lif_layer #(
      .NUM_INPUTS (NI),
      .NUM_OUTPUTS(NO),
      .WEIGHT_SIZE(WS),
      .POT_SIZE   (PS),
      .THRESH     (TH),
      .RESET      (RS),
      .REFRAC     (RF),
      .LEAK       (LK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spike_valid(spike_valid),
      .spike_in   (spike_in),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .spike_out  (spike_out),
      .refrac_busy(refrac_busy)
   );

   // Reference model state
   int        m_w   [NW];
   int        m_pot [NO];
   int        m_cnt [NO];
   bit [NO-1:0] m_spk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NW; k++) m_w[k] = 0;
      for (int j = 0; j < NO; j++) begin
         m_pot[j] = 0;
         m_cnt[j] = 0;
      end
      m_spk = '0;
   endtask

   function automatic logic [NO-1:0] model_busy();
      logic [NO-1:0] b;
      for (int j = 0; j < NO; j++) b[j] = (m_cnt[j] != 0);
      return b;
   endfunction

   // One clock: drive inputs at negedge, advance model, check after posedge.
   task automatic step(input bit v, input logic [NI-1:0] s, input bit we,
                       input int addr, input int data);
      logic signed [WS-1:0] d8;
      int acc;
      @(negedge clk);
      spike_valid = v;
      spike_in    = s;
      wr_en       = we;
      wr_addr     = addr[2:0];
      wr_data     = data[WS-1:0];
      if (v) begin
         for (int j = 0; j < NO; j++) begin
            if (m_cnt[j] > 0) begin
               m_cnt[j]--;
               m_pot[j] = RS;
               m_spk[j] = 1'b0;
            end else begin
               acc = m_pot[j];
               for (int i = 0; i < NI; i++) if (s[i]) acc += m_w[j*NI + i];
`ifdef LIF_LEAK_EN
               acc -= LK;
`endif
               if (acc > PMAX) acc = PMAX;
               if (acc < PMIN) acc = PMIN;
               if (acc < RS) acc = RS;
               if (acc >= TH) begin
                  m_spk[j] = 1'b1;
                  m_pot[j] = RS;
                  m_cnt[j] = RF;
               end else begin
                  m_spk[j] = 1'b0;
                  m_pot[j] = acc;
               end
            end
         end
      end else begin
         m_spk = '0;
      end
      if (we && addr < NW) begin
         d8 = data[WS-1:0];
         m_w[addr] = int'(d8);
      end
      @(posedge clk);
      #1;
      check("spike_out", 32'(spike_out), 32'(m_spk));
      check("refrac_busy", 32'(refrac_busy), 32'(model_busy()));
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b0;
      spike_valid = 1'b0;
      wr_en = 1'b0;
      model_reset();
      #1;
      check("rst_spike", 32'(spike_out), 32'd0);
      check("rst_busy", 32'(refrac_busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int t_fire[$];
      logic [NI-1:0] rs;
      int exp_first, exp_second;

      model_reset();
      #1;
      check("por_spike", 32'(spike_out), 32'd0);
      check("por_busy", 32'(refrac_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // All weights zero: no activity.
      for (int t = 0; t < 10; t++) begin
         step(1'b1, 4'b1111, 1'b0, 0, 0);
         check("zero_w_spike", 32'(spike_out), 32'd0);
      end

      // weight[0]=5, in0 each step: pulse timing and refractory window.
      reset_dut();
      step(1'b0, '0, 1'b1, 0, 5);
      for (int t = 1; t <= 14; t++) begin
         step(1'b1, 4'b0001, 1'b0, 0, 0);
         if (spike_out[0]) t_fire.push_back(t);
         check("out1_quiet", 32'(spike_out[1]), 32'd0);
      end
`ifdef LIF_LEAK_EN
      exp_first = 4; exp_second = 13;
`else
      exp_first = 3; exp_second = 11;
`endif
      check("pulse_count", 32'(t_fire.size()), 32'd2);
      if (t_fire.size() >= 2) begin
         check("first_pulse_t", 32'(t_fire[0]), 32'(exp_first));
         check("second_pulse_t", 32'(t_fire[1]), 32'(exp_second));
      end

      // Negative weight clamps the potential at the floor.
      reset_dut();
      step(1'b0, '0, 1'b1, 0, 10);
      step(1'b0, '0, 1'b1, 1, -20);
      step(1'b1, 4'b0001, 1'b0, 0, 0);
      step(1'b1, 4'b0010, 1'b0, 0, 0);
      step(1'b1, 4'b0001, 1'b0, 0, 0);
      check("clamp_nofire", 32'(spike_out[0]), 32'd0);
      step(1'b1, 4'b0001, 1'b0, 0, 0);
      check("clamp_fire", 32'(spike_out[0]), 32'd1);

      // Write coinciding with a timestep: that step still uses the old weight.
      reset_dut();
      step(1'b0, '0, 1'b1, 0, 5);
      step(1'b1, 4'b0001, 1'b1, 0, 9);
      step(1'b1, 4'b0001, 1'b0, 0, 0);
      check("wr_old_step2", 32'(spike_out[0]), 32'd0);
      step(1'b1, 4'b0001, 1'b0, 0, 0);
      check("wr_old_step3", 32'(spike_out[0]), 32'd1);

      // Asynchronous reset in the middle of a refractory window.
      reset_dut();
      step(1'b0, '0, 1'b1, 0, 5);
      for (int t = 0; t < 4; t++) step(1'b1, 4'b0001, 1'b0, 0, 0);
      check("pre_rst_busy", 32'(refrac_busy[0]), 32'd1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_spike", 32'(spike_out), 32'd0);
      check("async_busy", 32'(refrac_busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int t = 0; t < 6; t++) begin
         step(1'b1, 4'b0001, 1'b0, 0, 0);
         check("post_rst_quiet", 32'(spike_out), 32'd0);
      end

`ifdef LIF_LEAK_EN
      // Idle valid steps let the potential leak to the floor: 12 -> 0.
      reset_dut();
      step(1'b0, '0, 1'b1, 0, 5);
      for (int t = 0; t < 3; t++) step(1'b1, 4'b0001, 1'b0, 0, 0);
      for (int t = 0; t < 14; t++) step(1'b1, 4'b0000, 1'b0, 0, 0);
      for (int t = 0; t < 3; t++) step(1'b1, 4'b0001, 1'b0, 0, 0);
      check("leak_decay_nofire", 32'(spike_out[0]), 32'd0);
      step(1'b1, 4'b0001, 1'b0, 0, 0);
      check("leak_decay_fire", 32'(spike_out[0]), 32'd1);
`endif

      // Random traffic against the model.
      reset_dut();
      for (int t = 0; t < 1500; t++) begin
         rs = NI'($urandom);
         step(($urandom_range(0, 3) != 0), rs, ($urandom_range(0, 9) < 3),
              int'($urandom_range(0, NW - 1)), int'($urandom_range(0, 40)) - 15);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
